// File: rtl/id_regfile_bypass_pkg.sv
// id_regfile_bypass_pkg
//   Shared widths, zip field offsets and the source-match helper for the
//   decode-stage register file / hazard unit.
//   Zip layouts (MSB..LSB):
//     rf zip : {we, waddr, wdata}
//     ex zip : {res_from_mem, we, waddr, wdata}
//   The EX zip is the rf zip with a load flag on top, so the rf-zip offsets
//   apply to the low RF_ZIP_W bits of both.
package id_regfile_bypass_pkg;

    // Default geometry. The top-level DATA_W/ADDR_W parameters default to
    // these, and src_match() is sized by them, so keep them in step.
    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    localparam int RF_ZIP_W  = 1 + RF_ADDR_W + RF_DATA_W;
    localparam int EX_ZIP_W  = RF_ZIP_W + 1;

    localparam int WDATA_LSB = 0;
    localparam int WADDR_LSB = RF_DATA_W;
    localparam int WE_BIT    = RF_DATA_W + RF_ADDR_W;
    localparam int LOAD_BIT  = RF_ZIP_W;          // EX zip only

    // A producer stage matches a source when it really writes that register.
    // valid is ANDed first so a stage that is not valid contributes 0 even
    // when its zip fields are unknown.
    function automatic logic src_match(
        input logic                 valid,
        input logic [RF_ZIP_W-1:0]  zip,
        input logic [RF_ADDR_W-1:0] addr,
        input logic                 used
    );
        return valid & zip[WE_BIT] & used & (addr != '0)
             & (zip[WADDR_LSB +: RF_ADDR_W] == addr);
    endfunction

endpackage

// File: rtl/id_regfile_bypass_regfile_2r1w.sv
// id_regfile_bypass_regfile_2r1w
//   2-read / 1-write general register file. No forwarding here; reads return
//   the stored value, r0 always reads 0 and writes to it are dropped.
//   Ports:
//     clk, resetn       clock, async active-low clear of every entry
//     we, waddr, wdata  write port (already qualified by the caller)
//     raddr1/2, rdata1/2  combinational read ports
module id_regfile_bypass_regfile_2r1w #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
)(
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/id_regfile_bypass.sv
// id_regfile_bypass
//   Decode-stage register file plus RAW hazard resolution. Takes the WB write
//   zip and the in-flight EX/MEM result zips, returns two resolved operands and
//   an interlock for ID (ready_go = ~hazard_stall), and counts stalled cycles.
//   Build option: REGFILE_BYPASS_EN
//     defined   : EX > MEM > WB forwarding, stall only on EX load-use.
//     undefined : only WB write-through; any EX or MEM match stalls.
//   Ports:
//     clk, resetn                    clock, async active-low reset
//     id_valid                       instruction present in ID
//     rs1_addr/rs2_addr, rs*_used    source indices and whether they are read
//     ex_valid, ex_rf_zip            {res_from_mem, we, waddr, wdata}
//     mem_valid, mem_rf_zip          {we, waddr, wdata}
//     wb_valid, wb_rf_zip            {we, waddr, wdata}, also the file write
//     rs1_data, rs2_data             resolved operands
//     hazard_stall                   ID must hold this cycle
//     stall_cnt                      saturating count of stalled cycles
module id_regfile_bypass
    import id_regfile_bypass_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int CNT_W  = 32
)(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       id_valid,
    input  logic [ADDR_W-1:0]          rs1_addr,
    input  logic [ADDR_W-1:0]          rs2_addr,
    input  logic                       rs1_used,
    input  logic                       rs2_used,
    input  logic                       ex_valid,
    input  logic [1+1+ADDR_W+DATA_W-1:0] ex_rf_zip,
    input  logic                       mem_valid,
    input  logic [1+ADDR_W+DATA_W-1:0] mem_rf_zip,
    input  logic                       wb_valid,
    input  logic [1+ADDR_W+DATA_W-1:0] wb_rf_zip,
    output logic [DATA_W-1:0]          rs1_data,
    output logic [DATA_W-1:0]          rs2_data,
    output logic                       hazard_stall,
    output logic [CNT_W-1:0]           stall_cnt
);

    logic              ex_load;
    logic [DATA_W-1:0] ex_wdata, mem_wdata, wb_wdata;
    logic [ADDR_W-1:0] src_addr [2];
    logic              src_used [2];
    logic [DATA_W-1:0] rf_rd    [2];
    logic [DATA_W-1:0] src_data [2];
    logic [1:0]        ex_hit, mem_hit, wb_hit;
    logic [CNT_W-1:0]  stall_cnt_q;

    assign ex_load   = ex_rf_zip[LOAD_BIT];
    assign ex_wdata  = ex_rf_zip[WDATA_LSB +: DATA_W];
    assign mem_wdata = mem_rf_zip[WDATA_LSB +: DATA_W];
    assign wb_wdata  = wb_rf_zip[WDATA_LSB +: DATA_W];

    assign src_addr[0] = rs1_addr;
    assign src_addr[1] = rs2_addr;
    assign src_used[0] = rs1_used;
    assign src_used[1] = rs2_used;

    id_regfile_bypass_regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rf (
        .clk    (clk),
        .resetn (resetn),
        .we     (wb_valid & wb_rf_zip[WE_BIT]),
        .waddr  (wb_rf_zip[WADDR_LSB +: ADDR_W]),
        .wdata  (wb_wdata),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rf_rd[0]),
        .rdata2 (rf_rd[1])
    );

    // Per-source hit vectors and operand selection. Index 0 is rs1, 1 is rs2.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            ex_hit[s]  = src_match(ex_valid,  ex_rf_zip[RF_ZIP_W-1:0],
                                   src_addr[s], src_used[s]);
            mem_hit[s] = src_match(mem_valid, mem_rf_zip, src_addr[s], src_used[s]);
            wb_hit[s]  = src_match(wb_valid,  wb_rf_zip,  src_addr[s], src_used[s]);

            // r0 never hits (src_match excludes it) and the file returns 0
            // for it, so index 0 always resolves to 0 without a special case.
            src_data[s] = rf_rd[s];
`ifdef REGFILE_BYPASS_EN
            // Youngest producer wins. A load in EX has no data yet; it is
            // skipped here and the stall below holds ID until it reaches MEM.
            if (ex_hit[s] && !ex_load) src_data[s] = ex_wdata;
            else if (mem_hit[s])       src_data[s] = mem_wdata;
            else if (wb_hit[s])        src_data[s] = wb_wdata;
`else
            // WB write-through only: the file is written at this same edge,
            // so returning wb data avoids a stall for the WB stage.
            if (wb_hit[s]) src_data[s] = wb_wdata;
`endif
        end
    end

    assign rs1_data = src_data[0];
    assign rs2_data = src_data[1];

`ifdef REGFILE_BYPASS_EN
    assign hazard_stall = id_valid & ex_load & (|ex_hit);
`else
    assign hazard_stall = id_valid & ((|ex_hit) | (|mem_hit));
`endif

    // Saturating stall counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else if (hazard_stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
